// File: rtl/if_fetch_queue.sv
// if_fetch_queue: owns the fetch PC, issues pipelined instruction reads with a
// credit limit, and buffers returned words with their PCs in a DEPTH-entry queue
// that feeds decode. A redirect flushes the queue and marks every in-flight read
// as stale so that its response is dropped when it returns.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0010)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      pc_src,
    input  logic [27:0]     offset28,
    input  logic [XLEN-1:0] beq_target,
    input  logic [XLEN-1:0] jr_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_4,
    input  logic            id_ready
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   outst_reg, outst_next;
    logic [CW-1:0]   drop_reg, drop_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [XLEN-1:0] instr_slot [DEPTH];
    logic [XLEN-1:0] pc_slot    [DEPTH];

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [CW:0]     credit_used;
    logic            accept;
    logic            push;
    logic            pop;

    assign redirect = (pc_src != 2'b00);

    // Select the redirect target; jumps keep the upper bits of the head's PC+4.
    always_comb begin
        target = jr_target;
        case (pc_src)
            2'b01:   target = {id_pc_4[XLEN-1:28], offset28};
            2'b10:   target = beq_target;
            default: target = jr_target;
        endcase
    end

    // Slots already owned by queued words or by live (non-stale) reads.
    assign credit_used = {1'b0, count_reg} + {1'b0, outst_reg} - {1'b0, drop_reg};

    assign imem_req  = reset & ~redirect & (outst_reg < DEPTH_C)
                     & (credit_used < {1'b0, DEPTH_C});
    assign imem_addr = fetch_pc_reg;
    assign accept    = imem_req & imem_ready;
    assign push      = imem_rvalid & ~redirect & (drop_reg == '0);
    assign pop       = id_valid & id_ready & ~redirect;

    assign id_valid = (count_reg != '0);
    assign id_instr = instr_slot[rd_ptr_reg];
    assign id_pc    = pc_slot[rd_ptr_reg];
    assign id_pc_4  = id_pc + FOUR;

    // Next-state for PCs, occupancy, in-flight and stale-response counters.
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        resp_pc_next  = resp_pc_reg;
        count_next    = count_reg;
        outst_next    = outst_reg;
        drop_next     = drop_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        if (redirect) begin
            // Nothing issues this cycle; whatever is still in flight becomes stale.
            fetch_pc_next = target;
            resp_pc_next  = target;
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            outst_next    = outst_reg - CW'(imem_rvalid);
            drop_next     = outst_reg - CW'(imem_rvalid);
        end else begin
            outst_next = outst_reg + CW'(accept) - CW'(imem_rvalid);
            if (accept) begin
                fetch_pc_next = fetch_pc_reg + FOUR;
            end
            if (imem_rvalid) begin
                if (drop_reg != '0) begin
                    drop_next = drop_reg - CW'(1);
                end else begin
                    resp_pc_next = resp_pc_reg + FOUR;
                end
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            count_reg    <= '0;
            outst_reg    <= '0;
            drop_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            resp_pc_reg  <= resp_pc_next;
            count_reg    <= count_next;
            outst_reg    <= outst_next;
            drop_reg     <= drop_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [XLEN-1:0] instr_q;
            logic [XLEN-1:0] pc_q;

            // Capture a returned word with its PC when this slot is the write target.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    instr_q <= '0;
                    pc_q    <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    instr_q <= imem_rdata;
                    pc_q    <= resp_pc_reg;
                end
            end

            assign instr_slot[gi] = instr_q;
            assign pc_slot[gi]    = pc_q;
        end
    endgenerate

    // Counter range checks: the credit rule must keep every counter in bounds.
    a_outst_range: assert property (@(posedge clk) disable iff (!reset)
        outst_reg <= DEPTH_C);
    a_outst_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (outst_reg == '0)));
    a_count_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count_reg == DEPTH_C)));
    a_drop_bound: assert property (@(posedge clk) disable iff (!reset)
        drop_reg <= outst_reg);
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: an in-order memory model with programmable latency
// serves reads; the stimulus thread loads the expected PC stream for each phase
// and a monitor compares every word decode consumes against it.
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pc_src;
    logic [27:0] offset28;
    logic [31:0] beq_target, jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc_4;
    logic        id_ready;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          n_acc = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    logic        mem_ready_en = 1'b1;
    logic [31:0] exp_q [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];

    always #5 clk = ~clk;

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0010)) dut (
        .clk(clk), .reset(reset), .pc_src(pc_src), .offset28(offset28),
        .beq_target(beq_target), .jr_target(jr_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_4(id_pc_4), .id_ready(id_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory model: prepares rvalid/ready for the coming rising edge.
    always @(negedge clk) begin
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (!reset) begin
            pend_addr.delete();
            pend_due.delete();
            imem_ready = 1'b0;
        end else begin
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                void'(pend_due.pop_front());
                imem_rdata  = mem_word(pend_addr.pop_front());
                imem_rvalid = 1'b1;
            end
            imem_ready = mem_ready_en;
            if (imem_req && imem_ready) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + mem_lat);
                n_acc++;
            end
        end
    end

    // Monitor: every word consumed by decode is checked against the scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (reset && id_valid && id_ready && pc_src == 2'b00) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h, expected no pop", id_pc);
            end else begin
                e = exp_q.pop_front();
                $display("pop pc=%h instr=%h pc_4=%h (expected pc=%h)", id_pc, id_instr, id_pc_4, e);
                check("pop_pc", id_pc, e);
                check("pop_instr", id_instr, mem_word(e));
                check("pop_pc_4", id_pc_4, e + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int p0;
        reset = 1'b1; pc_src = 2'b00; offset28 = '0; beq_target = '0; jr_target = '0;
        id_ready = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        // Reset state
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h10);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc_4", id_pc_4, 32'h4);

        // 1: sequential streaming with a 1-cycle memory
        expect_seq(32'h10, 40);
        id_ready = 1'b1;
        reset = 1'b1;
        tick(20);
        check("t1_pops_ge10", 32'(n_pops >= 10), 32'd1);

        // 2: consumer stalled, credit limit of DEPTH requests
        id_ready = 1'b0; pc_src = 2'b10; beq_target = 32'h300;
        expect_seq(32'h300, 8); n_acc = 0;
        tick(1); pc_src = 2'b00;
        tick(10);
        check("t2_accepts", 32'(n_acc), 32'd4);
        check("t2_req_blocked", 32'(imem_req), 32'd0);
        check("t2_head_pc", id_pc, 32'h300);
        p0 = n_pops;
        id_ready = 1'b1;
        tick(1); id_ready = 1'b0;
        tick(6);
        check("t2_one_pop", 32'(n_pops - p0), 32'd1);
        check("t2_accepts_after_pop", 32'(n_acc), 32'd5);
        check("t2_req_blocked_again", 32'(imem_req), 32'd0);

        // 3: 3-cycle memory, three reads in flight, then a branch
        mem_lat = 3; pc_src = 2'b10; beq_target = 32'h500;
        expect_seq(32'h500, 0); n_acc = 0;
        tick(1); pc_src = 2'b00;
        tick(3);
        check("t3_in_flight", 32'(n_acc), 32'd3);
        pc_src = 2'b10; beq_target = 32'h100; id_ready = 1'b1;
        expect_seq(32'h100, 20); p0 = n_pops;
        tick(1); pc_src = 2'b00;
        check("t3_queue_empty", 32'(id_valid), 32'd0);
        check("t3_fetch_addr", imem_addr, 32'h100);
        tick(15);
        check("t3_pops_ge3", 32'(n_pops - p0 >= 3), 32'd1);

        // 4: jump using the head's PC+4, overridden by a jr on the next cycle
        mem_lat = 1; id_ready = 1'b0; pc_src = 2'b11; jr_target = 32'hA000_0000;
        expect_seq(32'h0, 0);
        tick(1); pc_src = 2'b00;
        tick(6);
        check("t4_head_pc", id_pc, 32'hA000_0000);
        check("t4_head_pc_4", id_pc_4, 32'hA000_0004);
        pc_src = 2'b01; offset28 = 28'h000_0040; n_acc = 0;
        tick(1);
        check("t4_jump_addr", imem_addr, 32'hA000_0040);
        pc_src = 2'b11; jr_target = 32'h200; id_ready = 1'b1;
        expect_seq(32'h200, 20); p0 = n_pops;
        tick(1); pc_src = 2'b00;
        check("t4_jr_wins", imem_addr, 32'h200);
        check("t4_no_issue", 32'(n_acc), 32'd0);
        tick(10);
        check("t4_pops_ge4", 32'(n_pops - p0 >= 4), 32'd1);

        // 5: fill the queue, then drain with simultaneous push and pop
        id_ready = 1'b0; pc_src = 2'b10; beq_target = 32'h400;
        expect_seq(32'h400, 30);
        tick(1); pc_src = 2'b00;
        tick(8);
        check("t5_full_valid", 32'(id_valid), 32'd1);
        check("t5_full_no_req", 32'(imem_req), 32'd0);
        check("t5_head_pc", id_pc, 32'h400);
        p0 = n_pops; id_ready = 1'b1;
        tick(20);
        check("t5_pops_ge12", 32'(n_pops - p0 >= 12), 32'd1);

        // 6: reset in the middle of a burst with two reads in flight
        mem_lat = 3; pc_src = 2'b10; beq_target = 32'h600;
        expect_seq(32'h0, 0); n_acc = 0;
        tick(1); pc_src = 2'b00;
        tick(2);
        check("t6_in_flight", 32'(n_acc), 32'd2);
        reset = 1'b0;
        #1;
        check("t6_rst_req", 32'(imem_req), 32'd0);
        check("t6_rst_valid", 32'(id_valid), 32'd0);
        check("t6_rst_addr", imem_addr, 32'h10);
        check("t6_rst_id_pc", id_pc, 32'h0);
        mem_lat = 1; expect_seq(32'h10, 20); p0 = n_pops;
        tick(2);
        reset = 1'b1;
        check("t6_restart_addr", imem_addr, 32'h10);
        tick(12);
        check("t6_pops_ge5", 32'(n_pops - p0 >= 5), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
